// File: rtl/message_stream_scheduler.sv
// Round-robin packet scheduler: grants one show-ahead input stream at a time and
// forwards a whole packet (header plus announced payload) before re-arbitrating.

module message_stream_lane #(
  parameter int LOG_N = 2,
  parameter int IDX   = 0
) (
  input  logic             valid,
  input  logic [LOG_N-1:0] sel,
  input  logic             active,
  output logic             read
);
  // Only the granted lane may pop, and only while its buffer has data.
  assign read = active && valid && (sel == LOG_N'(IDX));
endmodule

module message_stream_scheduler #(
  parameter int N_STREAMS             = 4,
  parameter int LOG_N_STREAMS         = 2,
  parameter int WIDTH                 = 32,
  parameter int MAX_PACKET_LENGTH     = 16,
  parameter int LOG_MAX_PACKET_LENGTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH*N_STREAMS-1:0]   in_data,
  input  logic [N_STREAMS-1:0]         in_valid,
  output logic [N_STREAMS-1:0]         in_read,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_nd,
  output logic                         out_header,
  output logic [LOG_N_STREAMS-1:0]     out_stream,
  output logic                         error
);
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, HEADER, BODY, ERROR} state_t;

  typedef struct packed {
    logic [WIDTH-1:0]         data;
    logic                     header;
    logic [LOG_N_STREAMS-1:0] stream;
  } out_word_t;

  state_t                           state, state_nxt;
  logic [LOG_N_STREAMS-1:0]         rr_ptr, rr_ptr_nxt;
  logic [LOG_N_STREAMS-1:0]         sel, sel_nxt, sel_inc;
  logic [LOG_MAX_PACKET_LENGTH-1:0] count, count_nxt;
  logic                             err_nxt;
  logic                             active, fwd, fwd_hdr;
  logic [N_STREAMS-1:0][WIDTH-1:0]  lane_data;
  logic [WIDTH-1:0]                 cur_word;
  logic                             cur_valid, cur_flag;
  logic [LOG_MAX_PACKET_LENGTH-1:0] cur_len;
  logic                             arb_hit;
  logic [LOG_N_STREAMS-1:0]         arb_idx;
  logic [LOG_N_STREAMS:0]           arb_sum;
  logic [STAGES:0]                  vld_pipe;
  out_word_t                        out_q;

  assign lane_data = in_data;
  assign cur_word  = lane_data[sel];
  assign cur_valid = in_valid[sel];
  assign cur_flag  = cur_word[WIDTH-1];
  assign cur_len   = cur_word[LOG_MAX_PACKET_LENGTH-1:0];
  assign sel_inc   = (sel == LOG_N_STREAMS'(N_STREAMS-1)) ? '0 : sel + 1'b1;

  for (genvar i = 0; i < N_STREAMS; i++) begin : g_lane
    message_stream_lane #(
      .LOG_N (LOG_N_STREAMS),
      .IDX   (i)
    ) u_lane (
      .valid  (in_valid[i]),
      .sel    (sel),
      .active (active),
      .read   (in_read[i])
    );
  end

  // Scan from rr_ptr upward; iterating high-to-low lets the nearest hit win.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = rr_ptr;
    arb_sum = '0;
    for (int k = N_STREAMS - 1; k >= 0; k--) begin
      arb_sum = {1'b0, rr_ptr} + (LOG_N_STREAMS+1)'(k);
      if (arb_sum >= (LOG_N_STREAMS+1)'(N_STREAMS))
        arb_sum = arb_sum - (LOG_N_STREAMS+1)'(N_STREAMS);
      if (in_valid[arb_sum[LOG_N_STREAMS-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = arb_sum[LOG_N_STREAMS-1:0];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    rr_ptr_nxt = rr_ptr;
    count_nxt  = count;
    err_nxt    = error;
    active     = 1'b0;
    fwd        = 1'b0;
    fwd_hdr    = 1'b0;
    case (state)
      IDLE: begin
        if (arb_hit) begin
          sel_nxt   = arb_idx;
          state_nxt = HEADER;
        end
      end
      HEADER: begin
        active = 1'b1;
        if (cur_valid) begin
          // A non-header word here means the stream lost framing; drop it and lock up.
          if (!cur_flag) begin
            err_nxt   = 1'b1;
            state_nxt = ERROR;
          end else begin
            fwd     = 1'b1;
            fwd_hdr = 1'b1;
            if (cur_len == '0) begin
              rr_ptr_nxt = sel_inc;
              state_nxt  = IDLE;
            end else begin
              count_nxt = cur_len;
              state_nxt = BODY;
            end
          end
        end
      end
      BODY: begin
        active = 1'b1;
        if (cur_valid) begin
          fwd       = 1'b1;
          count_nxt = count - 1'b1;
          if (count == LOG_MAX_PACKET_LENGTH'(1)) begin
            rr_ptr_nxt = sel_inc;
            state_nxt  = IDLE;
          end
        end
      end
      ERROR: ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      sel    <= '0;
      count  <= '0;
      error  <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      sel    <= sel_nxt;
      count  <= count_nxt;
      error  <= err_nxt;
    end
  end

  assign vld_pipe[0] = fwd;

  // Data and stream hold across idle cycles; header flag only meaningful with out_nd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      out_q              <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      out_q.header       <= fwd_hdr;
      if (fwd) begin
        out_q.data   <= cur_word;
        out_q.stream <= sel;
      end
    end
  end

  assign out_nd     = vld_pipe[STAGES];
  assign out_data   = out_q.data;
  assign out_header = out_q.header;
  assign out_stream = out_q.stream;

endmodule
